uc_multiciclo: RTL and testbench

- Multi-cycle control unit for the CPU datapath (PC, register bank, ALU, zero-flag register).
- Sequences every instruction through FETCH -> DECODE -> EXEC with a req/ack handshake to instruction memory.
- Emits the existing datapath strobes: s_inc, s_inm, we3, wez, op_alu, plus PC and instruction-register write enables.
- Opcode map: 1xxxxx = ALU op with op_alu = opcode[4:2]; 0000xx = LI; 000100 = J; 000101 = JZ; 000110 = JNZ.

---
 rtl/uc_pkg.sv | 25 ++
 rtl/uc_mc_dec.sv | 31 +++
 rtl/uc_multiciclo.sv | 136 +++++++++++++
 tb/tb_uc_multiciclo.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared types and opcode constants for the multi-cycle control unit.
// State encoding, opcode map and the ALU field helper live here.
package uc_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [5:0] OP_J    = 6'b000100;
  localparam logic [5:0] OP_JZ   = 6'b000101;
  localparam logic [5:0] OP_JNZ  = 6'b000110;
  localparam logic [5:0] OP_HALT = 6'b000111;

  localparam logic [3:0] OP_LI_PFX  = 4'b0000;
  localparam int         OP_ALU_BIT = 5;

  // ALU operation carried in bits [4:2] of an ALU-class opcode
  function automatic logic [2:0] alu_field(input logic [5:0] op);
    return op[4:2];
  endfunction

endpackage

// File: rtl/uc_mc_dec.sv
// Combinational opcode classifier for the multi-cycle control unit.
// With UC_MC_HALT_EN defined, 000111 is HALT; otherwise it is flagged illegal.
module uc_mc_dec
  import uc_pkg::*;
(
  input  logic [5:0] op,
  output logic       is_alu,
  output logic       is_li,
  output logic       is_j,
  output logic       is_jz,
  output logic       is_jnz,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    is_alu = op[OP_ALU_BIT];
    is_li  = (op[5:2] == OP_LI_PFX);
    is_j   = (op == OP_J);
    is_jz  = (op == OP_JZ);
    is_jnz = (op == OP_JNZ);
`ifdef UC_MC_HALT_EN
    is_halt    = (op == OP_HALT);
    is_illegal = 1'b0;
`else
    is_halt    = 1'b0;
    is_illegal = (op == OP_HALT);
`endif
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit: FETCH -> DECODE -> EXEC with an imem req/ack handshake.
// Optional HALT instruction and HALTED state are enabled by defining UC_MC_HALT_EN.
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int ALUW = 3
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [OPW-1:0]  imem_op,
  input  logic            z,
  output logic            pc_we,
  output logic            ir_we,
  output logic            s_inc,
  output logic            s_inm,
  output logic            we3,
  output logic            wez,
  output logic [ALUW-1:0] op_alu,
  output logic            busy,
  output logic            illegal
);

  state_t          state;
  state_t          next_state;
  logic [OPW-1:0]  opcode;
  logic [OPW-1:0]  opcode_next;
  logic            illegal_q;

  logic            imem_req_q;
  logic            busy_q;
  logic            pc_we_q;
  logic            we3_q;
  logic            wez_q;
  logic            s_inm_q;
  logic [ALUW-1:0] op_alu_q;

  logic is_alu;
  logic is_li;
  logic is_j;
  logic is_jz;
  logic is_jnz;
  logic is_halt;
  logic is_illegal;

  // Classifying opcode_next lets the registered strobes be set up for the
  // state being entered; in DECODE/EXEC it equals the latched opcode.
  uc_mc_dec u_dec (
    .op         (opcode_next),
    .is_alu     (is_alu),
    .is_li      (is_li),
    .is_j       (is_j),
    .is_jz      (is_jz),
    .is_jnz     (is_jnz),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  always_comb begin
    opcode_next = opcode;
    next_state  = state;
    case (state)
      FETCH: begin
        if (imem_ack) begin
          opcode_next = imem_op;
          next_state  = DECODE;
        end
      end
      DECODE: next_state = EXEC;
      EXEC: begin
        next_state = FETCH;
`ifdef UC_MC_HALT_EN
        if (is_halt) next_state = HALTED;
`endif
      end
      HALTED: begin
`ifdef UC_MC_HALT_EN
        next_state = HALTED;
`else
        next_state = FETCH;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= FETCH;
      opcode     <= '0;
      illegal_q  <= 1'b0;
      imem_req_q <= 1'b1;
      busy_q     <= 1'b0;
      pc_we_q    <= 1'b0;
      we3_q      <= 1'b0;
      wez_q      <= 1'b0;
      s_inm_q    <= 1'b0;
      op_alu_q   <= '0;
    end else begin
      state  <= next_state;
      opcode <= opcode_next;
      if (state == DECODE && is_illegal) illegal_q <= 1'b1;
      imem_req_q <= (next_state == FETCH);
      busy_q     <= (next_state != FETCH);
      pc_we_q    <= (next_state == EXEC) && !is_halt;
      we3_q      <= (next_state == EXEC) && (is_alu || is_li);
      wez_q      <= (next_state == EXEC) && is_alu;
      s_inm_q    <= (next_state == EXEC) && is_li && !is_alu;
      op_alu_q   <= (next_state == DECODE || next_state == EXEC) ?
                    alu_field(opcode_next) : '0;
    end
  end

  // Jump conditions use z as it stands during EXEC, so s_inc stays combinational.
  always_comb begin
    s_inc = 1'b1;
    if (state == EXEC) begin
      if (is_j)        s_inc = 1'b0;
      else if (is_jz)  s_inc = ~z;
      else if (is_jnz) s_inc = z;
    end
  end

  // Gating with reset keeps a mid-instruction reset from producing any write.
  assign imem_req = imem_req_q & reset;
  assign ir_we    = reset & (state == FETCH) & imem_ack;
  assign pc_we    = pc_we_q & reset;
  assign we3      = we3_q & reset;
  assign wez      = wez_q & reset;
  assign s_inm    = s_inm_q & reset;
  assign op_alu   = op_alu_q;
  assign busy     = busy_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed testbench for uc_multiciclo; define UC_MC_HALT_EN to exercise HALT.
module tb_uc_multiciclo;

  logic       clk;
  logic       reset;
  logic       imem_req;
  logic       imem_ack;
  logic [5:0] imem_op;
  logic       z;
  logic       pc_we;
  logic       ir_we;
  logic       s_inc;
  logic       s_inm;
  logic       we3;
  logic       wez;
  logic [2:0] op_alu;
  logic       busy;
  logic       illegal;

  int compared   = 0;
  int mismatched = 0;

  logic [10:0] obs;
  logic [10:0] exp_v;

  uc_multiciclo #(.OPW(6), .ALUW(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .imem_req (imem_req),
    .imem_ack (imem_ack),
    .imem_op  (imem_op),
    .z        (z),
    .pc_we    (pc_we),
    .ir_we    (ir_we),
    .s_inc    (s_inc),
    .s_inm    (s_inm),
    .we3      (we3),
    .wez      (wez),
    .op_alu   (op_alu),
    .busy     (busy),
    .illegal  (illegal)
  );

  // Layout: imem_req, ir_we, pc_we, s_inc, s_inm, we3, wez, busy, op_alu[2:0]
  assign obs = {imem_req, ir_we, pc_we, s_inc, s_inm, we3, wez, busy, op_alu};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    exp_v = 11'b0_0_0_1_0_0_0_0_000;
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %b want %b", obs, exp_v);
    end
    compared++;
    if (illegal !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_illegal: got %b want %b", illegal, 1'b0);
    end
    next_cycle();
    imem_ack = 1'b1;
    imem_op  = 6'b101000;
    @(negedge clk);
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL reset_hold_with_ack: got %b want %b", obs, exp_v);
    end
  endtask

  task automatic test_alu_add();
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    exp_v = 11'b1_1_0_1_0_0_0_0_000;
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL add_fetch: got %b want %b", obs, exp_v);
    end
    next_cycle();
    imem_op = 6'b000100;
    @(negedge clk);
    exp_v = 11'b0_0_0_1_0_0_0_1_010;
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL add_decode: got %b want %b", obs, exp_v);
    end
    next_cycle();
    @(negedge clk);
    exp_v = 11'b0_0_1_1_0_1_1_1_010;
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL add_exec: got %b want %b", obs, exp_v);
    end
    next_cycle();
    imem_ack = 1'b0;
    @(negedge clk);
    exp_v = 11'b1_0_0_1_0_0_0_0_000;
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL add_idle_fetch: got %b want %b", obs, exp_v);
    end
  endtask

  task automatic test_li_wait();
    imem_op  = 6'b000010;
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      exp_v = 11'b1_0_0_1_0_0_0_0_000;
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("[TB] FAIL li_wait[%0d]: got %b want %b", i, obs, exp_v);
      end
    end
    next_cycle();
    imem_ack = 1'b1;
    @(negedge clk);
    exp_v = 11'b1_1_0_1_0_0_0_0_000;
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL li_fetch_ack: got %b want %b", obs, exp_v);
    end
    next_cycle();
    imem_ack = 1'b0;
    @(negedge clk);
    exp_v = 11'b0_0_0_1_0_0_0_1_000;
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL li_decode: got %b want %b", obs, exp_v);
    end
    next_cycle();
    @(negedge clk);
    exp_v = 11'b0_0_1_1_1_1_0_1_000;
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL li_exec: got %b want %b", obs, exp_v);
    end
  endtask

  task automatic test_jumps();
    logic [5:0] ops  [4] = '{6'b000101, 6'b000101, 6'b000110, 6'b000100};
    logic       zx   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       sinc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      imem_ack = 1'b1;
      imem_op  = ops[i];
      @(negedge clk);
      exp_v = 11'b1_1_0_1_0_0_0_0_000;
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("[TB] FAIL jump_fetch[%0d]: got %b want %b", i, obs, exp_v);
      end
      next_cycle();
      imem_ack = 1'b0;
      z = ~zx[i];
      next_cycle();
      z = zx[i];
      @(negedge clk);
      exp_v = {3'b001, sinc[i], 4'b0001, 3'b001};
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("[TB] FAIL jump_exec[%0d]: got %b want %b", i, obs, exp_v);
      end
    end
    z = 1'b0;
  endtask

`ifndef UC_MC_HALT_EN
  task automatic test_illegal();
    logic [5:0] ops [3] = '{6'b101000, 6'b000010, 6'b000100};
    next_cycle();
    imem_ack = 1'b1;
    imem_op  = 6'b000111;
    @(negedge clk);
    exp_v = 11'b1_1_0_1_0_0_0_0_000;
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL illegal_fetch: got %b want %b", obs, exp_v);
    end
    next_cycle();
    imem_ack = 1'b0;
    next_cycle();
    @(negedge clk);
    exp_v = 11'b0_0_1_1_0_0_0_1_001;
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL illegal_exec: got %b want %b", obs, exp_v);
    end
    compared++;
    if (illegal !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL illegal_flag: got %b want %b", illegal, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      imem_ack = 1'b1;
      imem_op  = ops[i];
      next_cycle();
      imem_ack = 1'b0;
      next_cycle();
      @(negedge clk);
      compared++;
      if (illegal !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL illegal_sticky[%0d]: got %b want %b", i, illegal, 1'b1);
      end
    end
  endtask
`else
  task automatic test_halt();
    next_cycle();
    imem_ack = 1'b1;
    imem_op  = 6'b000111;
    next_cycle();
    imem_ack = 1'b0;
    next_cycle();
    @(negedge clk);
    exp_v = 11'b0_0_0_1_0_0_0_1_001;
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL halt_exec: got %b want %b", obs, exp_v);
    end
    compared++;
    if (illegal !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL halt_no_illegal: got %b want %b", illegal, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      imem_ack = 1'b1;
      @(negedge clk);
      exp_v = 11'b0_0_0_1_0_0_0_1_000;
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("[TB] FAIL halt_hold[%0d]: got %b want %b", i, obs, exp_v);
      end
    end
    next_cycle();
    imem_ack = 1'b0;
    reset    = 1'b0;
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    exp_v = 11'b1_0_0_1_0_0_0_0_000;
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL halt_exit: got %b want %b", obs, exp_v);
    end
  endtask
`endif

  task automatic test_reset_decode();
    next_cycle();
    imem_ack = 1'b1;
    imem_op  = 6'b111100;
    @(negedge clk);
    exp_v = 11'b1_1_0_1_0_0_0_0_000;
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL rst_fetch_ack: got %b want %b", obs, exp_v);
    end
    next_cycle();
    imem_ack = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    exp_v = 11'b0_0_0_1_0_0_0_1_111;
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL rst_in_decode: got %b want %b", obs, exp_v);
    end
    next_cycle();
    @(negedge clk);
    exp_v = 11'b0_0_0_1_0_0_0_0_000;
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL rst_to_fetch: got %b want %b", obs, exp_v);
    end
    compared++;
    if (illegal !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rst_illegal_clear: got %b want %b", illegal, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      exp_v = 11'b1_0_0_1_0_0_0_0_000;
      compared++;
      if (obs !== exp_v) begin
        mismatched++;
        $display("[TB] FAIL rst_release[%0d]: got %b want %b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] seq [6] = '{11'b1_1_0_1_0_0_0_0_000, 11'b0_0_0_1_0_0_0_1_001,
                             11'b0_0_1_1_0_1_1_1_001, 11'b1_1_0_1_0_0_0_0_000,
                             11'b0_0_0_1_0_0_0_1_100, 11'b0_0_1_1_0_1_1_1_100};
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      if (i == 0) begin
        imem_ack = 1'b1;
        imem_op  = 6'b100100;
      end
      if (i == 1) imem_op = 6'b110000;
      if (i == 4) imem_ack = 1'b0;
      @(negedge clk);
      compared++;
      if (obs !== seq[i]) begin
        mismatched++;
        $display("[TB] FAIL b2b[%0d]: got %b want %b", i, obs, seq[i]);
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    imem_ack = 1'b0;
    imem_op  = 6'b000000;
    z        = 1'b0;
    $display("[TB] starting uc_multiciclo directed tests");
    test_reset();
    test_alu_add();
    test_li_wait();
    test_jumps();
`ifndef UC_MC_HALT_EN
    test_illegal();
`else
    test_halt();
`endif
    test_reset_decode();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
